// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: memory index/data, control, and decode handshake.
// The fetch unit uses master; the memory/decode/testbench side uses slave.
interface instruction_fetch_if #(
  parameter int ADDR_W  = 3,
  parameter int INSTR_W = 12
);
  logic               start;
  logic               stop;
  logic [ADDR_W-1:0]  mem_index;
  logic [INSTR_W-1:0] mem_data;
  logic               branch_valid;
  logic [ADDR_W-1:0]  branch_target;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic               busy;

  modport master (
    input  start, stop, mem_data,
    input  branch_valid, branch_target,
    input  instr_ready,
    output mem_index, instr_valid,
    output instr, instr_pc, busy
  );

  modport slave (
    output start, stop, mem_data,
    output branch_valid, branch_target,
    output instr_ready,
    input  mem_index, instr_valid,
    input  instr, instr_pc, busy
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC-driven memory read, one-entry output slot.
// Define IFETCH_WRAP_EN to wrap past the last address instead of stopping.
module instruction_fetch #(
  parameter int ADDR_W  = 3,
  parameter int INSTR_W = 12
) (
  input  logic clk,
  input  logic reset,
  instruction_fetch_if.master bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_valid;
  logic               r_busy;

  logic               w_free;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic               w_last;

  assign w_free   = !r_valid || bus.instr_ready;
  assign w_pc_inc = ADDR_W'((int'(r_pc) + 1) % DEPTH);
  assign w_last   = (int'(r_pc) == DEPTH - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else if (bus.stop) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else if (bus.branch_valid &&
                 r_state != S_IDLE) begin
      // Redirect flushes the slot even if decode accepted it.
      r_state <= S_FETCH;
      r_pc    <= bus.branch_target;
      r_valid <= 1'b0;
      r_busy  <= 1'b1;
    end else if (bus.start &&
                 r_state != S_FETCH) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_busy  <= 1'b1;
      if (w_free) r_valid <= 1'b0;
    end else if (r_state == S_FETCH && w_free) begin
      r_instr    <= bus.mem_data;
      r_instr_pc <= r_pc;
      r_valid    <= 1'b1;
      r_pc       <= w_pc_inc;
`ifndef IFETCH_WRAP_EN
      if (w_last) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
      end
`endif
    end else if (w_free) begin
      r_valid <= 1'b0;
    end
  end

`ifdef IFETCH_WRAP_EN
  logic w_unused;
  assign w_unused = w_last;
`endif

  assign bus.mem_index   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
// Covers reset, streaming, stall, branch, stop, end of program, async reset.
module tb_instruction_fetch;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [11:0] mem [8];

  instruction_fetch_if #(.ADDR_W(3), .INSTR_W(12)) bus ();

  instruction_fetch #(.ADDR_W(3), .INSTR_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mem_data = mem[bus.mem_index];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input string tag,
                      input logic [11:0] ei,
                      input logic [2:0] ep);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 1);
    chk({tag, "_instr"}, 32'(bus.instr), 32'(ei));
    chk({tag, "_pc"}, 32'(bus.instr_pc), 32'(ep));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) mem[i] = 12'(i);
    reset              = 1'b0;
    bus.start          = 1'b0;
    bus.stop           = 1'b0;
    bus.branch_valid   = 1'b0;
    bus.branch_target  = 3'd0;
    bus.instr_ready    = 1'b1;

    #12;
    chk("rst_index", 32'(bus.mem_index), 0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_instr", 32'(bus.instr), 0);
    chk("rst_ipc", 32'(bus.instr_pc), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b1;

    // Streaming run from start.
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_valid", 32'(bus.instr_valid), 0);
    chk("start_index", 32'(bus.mem_index), 0);
    for (int i = 0; i < 8; i++) begin
      step();
      slot("stream", 12'(i), 3'(i));
      chk("stream_index", 32'(bus.mem_index),
          32'((i + 1) % 8));
`ifdef IFETCH_WRAP_EN
      chk("wrap_busy", 32'(bus.busy), 1);
`endif
    end

`ifdef IFETCH_WRAP_EN
    step();
    slot("wrap0", 12'd0, 3'd0);
    chk("wrap0_busy", 32'(bus.busy), 1);
    step();
    slot("wrap1", 12'd1, 3'd1);
    chk("wrap1_busy", 32'(bus.busy), 1);
`else
    chk("done_busy", 32'(bus.busy), 0);
    step();
    chk("done_valid", 32'(bus.instr_valid), 0);
    chk("done_busy2", 32'(bus.busy), 0);
    chk("done_index", 32'(bus.mem_index), 0);
    step();
    chk("done_hold", 32'(bus.instr_valid), 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("restart_busy", 32'(bus.busy), 1);
    step();
    slot("restart", 12'd0, 3'd0);
`endif

    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("stop_valid", 32'(bus.instr_valid), 0);
    chk("stop_busy", 32'(bus.busy), 0);
    chk("stop_index", 32'(bus.mem_index), 0);

    // Backpressure on instruction 3.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    slot("pre_stall", 12'd3, 3'd3);
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      slot("stall", 12'd3, 3'd3);
      chk("stall_index", 32'(bus.mem_index), 4);
    end
    bus.instr_ready = 1'b1;
    step();
    slot("unstall", 12'd4, 3'd4);

    // Branch to 6 while instr_pc = 2.
    bus.stop = 1'b1;
    step();
    bus.stop  = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    slot("pre_br", 12'd2, 3'd2);
    bus.branch_valid  = 1'b1;
    bus.branch_target = 3'd6;
    step();
    bus.branch_valid = 1'b0;
    chk("br_flush", 32'(bus.instr_valid), 0);
    chk("br_index", 32'(bus.mem_index), 6);
    chk("br_busy", 32'(bus.busy), 1);
    step();
    slot("br_tgt", 12'd6, 3'd6);

    // Stop outranks branch; instr keeps last value.
    bus.branch_valid  = 1'b1;
    bus.branch_target = 3'd5;
    bus.stop          = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("bs_valid", 32'(bus.instr_valid), 0);
    chk("bs_index", 32'(bus.mem_index), 0);
    chk("bs_busy", 32'(bus.busy), 0);
    chk("bs_instr", 32'(bus.instr), 6);
    step();
    bus.branch_valid = 1'b0;
    chk("idle_br_busy", 32'(bus.busy), 0);
    chk("idle_br_index", 32'(bus.mem_index), 0);

    // Async reset mid-fetch with data distinct from addresses.
    for (int i = 0; i < 8; i++) mem[i] = 12'hA50 + 12'(i);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    slot("pre_rst", 12'hA51, 3'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.instr_valid), 0);
    chk("arst_instr", 32'(bus.instr), 0);
    chk("arst_index", 32'(bus.mem_index), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    chk("post_rst_valid", 32'(bus.instr_valid), 0);
    chk("post_rst_busy", 32'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
